code_lock_ctrl: RTL and testbench

//  Parametrised sequential successor to the fixed 4-bit code comparator in mdac.

---
 rtl/code_lock_if.sv | 42 ++++
 rtl/code_lock_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_lock_if.sv
// ---------------------------------------------------------------------------
// code_lock_if
//   Keypad-side handshake bundle for code_lock_ctrl.
//   master : keypad decoder (drives digits, clear, prog; observes status)
//   slave  : code_lock_ctrl (consumes digits; drives status)
// Signals
//   digit_valid  master->slave  digit present this cycle
//   digit        master->slave  digit value, CODE_W bits
//   clear        master->slave  abort entry / relock
//   prog         master->slave  request code reprogramming
//   ready        slave->master  digits accepted (idle/entry/prog)
//   unlocked     slave->master  unlock window active
//   fail         slave->master  one-cycle pulse on mismatch
//   locked_out   slave->master  lockout window active
//   tries_left   slave->master  remaining tries before lockout
// ---------------------------------------------------------------------------
interface code_lock_if #(
    parameter int CODE_W    = 4,
    parameter int MAX_TRIES = 3
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic              digit_valid;
    logic [CODE_W-1:0] digit;
    logic              clear;
    logic              prog;
    logic              ready;
    logic              unlocked;
    logic              fail;
    logic              locked_out;
    logic [TRY_W-1:0]  tries_left;

    modport master (
        output digit_valid, digit, clear, prog,
        input  ready, unlocked, fail, locked_out, tries_left
    );

    modport slave (
        input  digit_valid, digit, clear, prog,
        output ready, unlocked, fail, locked_out, tries_left
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// code_lock_ctrl
//   Sequential code lock: collects DIGITS digits (digit 0 = LS slice, entered
//   first), compares the whole entry against the stored code, then opens a
//   timed unlock window or counts a failed try. MAX_TRIES consecutive
//   failures start a timed lockout.
//
//   Optional feature macro: CODE_PROG_EN
//     defined   : prog in OPEN enters PROG; the next DIGITS digits replace
//                 the code (clear aborts and keeps the old code).
//     undefined : prog ignored, code fixed at DEFAULT_CODE.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    code_lock_if.slave (digit_valid, digit, clear, prog in;
//          ready, unlocked, fail, locked_out, tries_left out)
//
// Timing: last digit accepted at edge N -> CHECK; the comparison result is
// registered at N+1 and the outcome (unlocked / fail / locked_out) appears
// at N+2.
// ---------------------------------------------------------------------------
module code_lock_ctrl #(
    parameter int                        CODE_W       = 4,
    parameter int                        DIGITS       = 4,
    parameter logic [CODE_W*DIGITS-1:0]  DEFAULT_CODE = 16'hEEEE,
    parameter int                        MAX_TRIES    = 3,
    parameter int                        UNLOCK_CYC   = 8,
    parameter int                        LOCKOUT_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    code_lock_if.slave  bus
);

    localparam int CODE_BITS = CODE_W * DIGITS;
    localparam int CNT_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TRY_W     = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX   = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

`ifdef CODE_PROG_EN
    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_OPEN, ST_LOCKOUT, ST_PROG} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_OPEN, ST_LOCKOUT} state_t;
`endif

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CODE_W-1:0] entry_q [DIGITS];
    logic [CODE_BITS-1:0] entry_flat;
    logic              chk_phase_q;   // 0: compare cycle, 1: decide cycle
    logic              chk_match_q;
    logic [TMR_W-1:0]  timer_q;
    logic [TRY_W-1:0]  tries_q;
    logic [TRY_W-1:0]  tries_dec;
    logic              ready_q;
    logic              unlocked_q;
    logic              fail_q;
    logic              locked_out_q;
    logic [CODE_BITS-1:0] code_q;

`ifdef CODE_PROG_EN
    logic [CODE_W-1:0]    shadow_q [DIGITS];
    logic [CODE_BITS-1:0] shadow_flat;   // shadow with the current digit merged in
`else
    logic prog_unused;
    assign prog_unused = bus.prog;
    assign code_q      = DEFAULT_CODE;
`endif

    // NOTE: every variable in always_comb gets a value before any condition,
    // so no path leaves it holding its old value (which would infer a latch).
    always_comb begin
        entry_flat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            entry_flat[i*CODE_W +: CODE_W] = entry_q[i];
        end
        tries_dec = tries_q;
        if (tries_q != '0) begin
            tries_dec = tries_q - TRY_W'(1);
        end
    end

`ifdef CODE_PROG_EN
    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            shadow_flat[i*CODE_W +: CODE_W] = (CNT_W'(i) == cnt_q) ? bus.digit : shadow_q[i];
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            // NOTE: the entry digit storage is reset on purpose: a stale
            // partial code must never survive a reset.
            for (int i = 0; i < DIGITS; i++) begin
                entry_q[i] <= '0;
            end
            chk_phase_q  <= 1'b0;
            chk_match_q  <= 1'b0;
            timer_q      <= '0;
            tries_q      <= TRY_W'(MAX_TRIES);
            ready_q      <= 1'b1;
            unlocked_q   <= 1'b0;
            fail_q       <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef CODE_PROG_EN
            code_q       <= DEFAULT_CODE;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= '0;
            end
`endif
        end else begin
            fail_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // clear wins over a simultaneous digit
                    if (bus.clear) begin
                        cnt_q <= '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            entry_q[i] <= '0;
                        end
                    end else if (bus.digit_valid) begin
                        entry_q[cnt_q] <= bus.digit;
                        if (cnt_q == LAST_IDX) begin
                            cnt_q       <= '0;
                            state_q     <= ST_CHECK;
                            ready_q     <= 1'b0;
                            chk_phase_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_CHECK: begin
                    if (!chk_phase_q) begin
                        // whole-sequence compare; no early abort on first wrong digit
                        chk_match_q <= (entry_flat == code_q);
                        chk_phase_q <= 1'b1;
                    end else begin
                        chk_phase_q <= 1'b0;
                        chk_match_q <= 1'b0;
                        for (int i = 0; i < DIGITS; i++) begin
                            entry_q[i] <= '0;
                        end
                        if (chk_match_q) begin
                            state_q    <= ST_OPEN;
                            unlocked_q <= 1'b1;
                            timer_q    <= TMR_W'(UNLOCK_CYC - 1);
                            tries_q    <= TRY_W'(MAX_TRIES);
                        end else begin
                            fail_q  <= 1'b1;
                            tries_q <= tries_dec;
                            if (tries_dec == '0) begin
                                state_q      <= ST_LOCKOUT;
                                locked_out_q <= 1'b1;
                                timer_q      <= TMR_W'(LOCKOUT_CYC - 1);
                            end else begin
                                state_q <= ST_IDLE;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_OPEN: begin
                    if (bus.clear || timer_q == '0) begin
                        state_q    <= ST_IDLE;
                        unlocked_q <= 1'b0;
                        ready_q    <= 1'b1;
`ifdef CODE_PROG_EN
                    end else if (bus.prog) begin
                        state_q    <= ST_PROG;
                        unlocked_q <= 1'b0;
                        ready_q    <= 1'b1;
                        cnt_q      <= '0;
`endif
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end

                ST_LOCKOUT: begin
                    // clear and digits are deliberately ignored here
                    if (timer_q == '0) begin
                        state_q      <= ST_IDLE;
                        locked_out_q <= 1'b0;
                        ready_q      <= 1'b1;
                        tries_q      <= TRY_W'(MAX_TRIES);
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end

`ifdef CODE_PROG_EN
                ST_PROG: begin
                    if (bus.clear) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            shadow_q[i] <= '0;
                        end
                    end else if (bus.digit_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            code_q  <= shadow_flat;
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            for (int i = 0; i < DIGITS; i++) begin
                                shadow_q[i] <= '0;
                            end
                        end else begin
                            shadow_q[cnt_q] <= bus.digit;
                            cnt_q           <= cnt_q + CNT_W'(1);
                        end
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.fail       = fail_q;
    assign bus.locked_out = locked_out_q;
    assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_code_lock_ctrl
//   Self-checking bench for code_lock_ctrl. The reference model tracks only
//   the stored code and the remaining-try count and predicts, per complete
//   entry, the observable outcome (window lengths, fail pulse, try count).
//   A second instance checks the CODE_W=8 / DIGITS=2 configuration.
// ---------------------------------------------------------------------------
module tb_code_lock_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int UNLOCK_CYC  = 8;
    localparam int LOCKOUT_CYC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    code_lock_if #(.CODE_W(4), .MAX_TRIES(MAX_TRIES)) bus ();
    code_lock_if #(.CODE_W(8), .MAX_TRIES(MAX_TRIES)) bus2 ();

    code_lock_ctrl #(
        .CODE_W(4), .DIGITS(4), .DEFAULT_CODE(16'hEEEE), .MAX_TRIES(MAX_TRIES),
        .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    code_lock_ctrl #(
        .CODE_W(8), .DIGITS(2), .DEFAULT_CODE(16'hA55A), .MAX_TRIES(MAX_TRIES),
        .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct packed {
        logic       unl_n1;
        logic       fail_n1;
        logic       ready_n1;
        logic       unl_at;
        logic       fail_at;
        logic       lo_at;
        logic [1:0] tries_at;
        logic [7:0] unl_len;
        logic [7:0] fail_len;
        logic [7:0] lo_len;
        logic       ready_after;
        logic [1:0] tries_after;
    } obs_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_tries = MAX_TRIES;
    logic [15:0] m_code  = 16'hEEEE;

    function automatic obs_t predict(input logic [15:0] seq);
        obs_t e;
        e = '0;
        if (seq == m_code) begin
            m_tries   = MAX_TRIES;
            e.unl_at  = 1'b1;
            e.unl_len = 8'(UNLOCK_CYC);
        end else begin
            if (m_tries > 0) m_tries = m_tries - 1;
            e.fail_at  = 1'b1;
            e.fail_len = 8'd1;
            if (m_tries == 0) begin
                e.lo_at  = 1'b1;
                e.lo_len = 8'(LOCKOUT_CYC);
            end
        end
        e.tries_at = 2'(m_tries);
        if (m_tries == 0) m_tries = MAX_TRIES;
        e.tries_after = 2'(m_tries);
        e.ready_after = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
        bus.digit       = '0;
    endtask

    task automatic send_seq(input logic [15:0] seq, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_digit(seq[4*i +: 4]);
        end
    endtask

    // Called right after the tick that accepted the last digit (edge N).
    task automatic observe(input bit inject, output obs_t o);
        o = '0;
        tick();  // edge N+1
        o.unl_n1   = bus.unlocked;
        o.fail_n1  = bus.fail;
        o.ready_n1 = bus.ready;
        tick();  // edge N+2
        o.unl_at   = bus.unlocked;
        o.fail_at  = bus.fail;
        o.lo_at    = bus.locked_out;
        o.tries_at = bus.tries_left;
        for (int k = 0; k < 64; k++) begin
            if (!(bus.unlocked || bus.fail || bus.locked_out)) break;
            if (bus.unlocked)   o.unl_len  = o.unl_len + 8'd1;
            if (bus.fail)       o.fail_len = o.fail_len + 8'd1;
            if (bus.locked_out) o.lo_len   = o.lo_len + 8'd1;
            if (inject) begin
                bus.digit_valid = 1'b1;
                bus.digit       = 4'hE;
            end
            tick();
        end
        bus.digit_valid = 1'b0;
        o.ready_after = bus.ready;
        o.tries_after = bus.tries_left;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++;
        if (bus.unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked got=%b exp=0", bus.unlocked); end
        checks++;
        if (bus.fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", bus.fail); end
        checks++;
        if (bus.locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked_out got=%b exp=0", bus.locked_out); end
        checks++;
        if (bus.tries_left !== 2'd3) begin errors++; $display("FAIL reset_tries got=%0d exp=3", bus.tries_left); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unlock();
        obs_t got, exp;
        send_seq(16'hEEEE, 0);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL unlock got=%p exp=%p", got, exp); end
    endtask

    task automatic test_lockout();
        obs_t got, exp;
        for (int t = 0; t < 3; t++) begin
            send_seq(16'h4321, 0);
            observe(t == 2, got);
            exp = predict(16'h4321);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL lockout_try%0d got=%p exp=%p", t, got, exp); end
        end
        send_seq(16'hEEEE, 1);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL after_lockout got=%p exp=%p", got, exp); end
    endtask

    task automatic test_clear();
        obs_t got, exp;
        send_digit(4'hE);
        send_digit(4'hE);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        send_seq(16'hEEEE, 0);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL clear_entry got=%p exp=%p", got, exp); end

        // clear together with a digit: the digit must be dropped
        bus.clear = 1'b1; bus.digit_valid = 1'b1; bus.digit = 4'hE;
        tick();
        bus.clear = 1'b0; bus.digit_valid = 1'b0;
        send_digit(4'hE); send_digit(4'hE); send_digit(4'hE);
        repeat (3) tick();
        checks++;
        if ({bus.ready, bus.unlocked, bus.fail} !== 3'b100) begin
            errors++; $display("FAIL clear_drop got=%b exp=100", {bus.ready, bus.unlocked, bus.fail});
        end
        send_digit(4'hE);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL clear_drop_unlock got=%p exp=%p", got, exp); end

        // clear during the unlock window relocks at the next edge
        send_seq(16'hEEEE, 0);
        repeat (4) tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_tries = MAX_TRIES;
        checks++;
        if ({bus.unlocked, bus.ready} !== 2'b01) begin
            errors++; $display("FAIL clear_open got=%b exp=01", {bus.unlocked, bus.ready});
        end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        for (int t = 0; t < 2; t++) begin
            send_seq(16'h4321, 0);
            observe(1'b0, got);
            exp = predict(16'h4321);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rst_pre%0d got=%p exp=%p", t, got, exp); end
        end
        send_seq(16'h4321, 0);
        repeat (6) tick();
        checks++;
        if (bus.locked_out !== 1'b1) begin errors++; $display("FAIL rst_mid_lockout got=%b exp=1", bus.locked_out); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.unlocked, bus.fail, bus.locked_out, bus.tries_left} !== 6'b100011) begin
            errors++; $display("FAIL rst_async_lockout got=%b exp=100011",
                               {bus.ready, bus.unlocked, bus.fail, bus.locked_out, bus.tries_left});
        end
        m_tries = MAX_TRIES;
        #1 rst_n = 1'b1;
        tick();
        send_digit(4'hE);
        send_digit(4'hE);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.unlocked, bus.fail, bus.locked_out, bus.tries_left} !== 6'b100011) begin
            errors++; $display("FAIL rst_async_entry got=%b exp=100011",
                               {bus.ready, bus.unlocked, bus.fail, bus.locked_out, bus.tries_left});
        end
        #1 rst_n = 1'b1;
        tick();
        send_seq(16'hEEEE, 0);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_then_unlock got=%p exp=%p", got, exp); end
    endtask

    task automatic test_wide();
        bus2.digit_valid = 1'b1;
        bus2.digit = 8'h5A; tick();
        bus2.digit = 8'hA5; tick();
        bus2.digit_valid = 1'b0;
        tick(); tick();
        checks++;
        if ({bus2.unlocked, bus2.fail} !== 2'b10) begin
            errors++; $display("FAIL wide_unlock got=%b exp=10", {bus2.unlocked, bus2.fail});
        end
        repeat (10) tick();
        bus2.digit_valid = 1'b1;
        bus2.digit = 8'hA5; tick();
        bus2.digit = 8'h5A; tick();
        bus2.digit_valid = 1'b0;
        tick(); tick();
        checks++;
        if ({bus2.unlocked, bus2.fail, bus2.tries_left} !== 4'b0110) begin
            errors++; $display("FAIL wide_fail got=%b exp=0110", {bus2.unlocked, bus2.fail, bus2.tries_left});
        end
        tick();
        checks++;
        if (bus2.fail !== 1'b0) begin errors++; $display("FAIL wide_fail_pulse got=%b exp=0", bus2.fail); end
    endtask

    task automatic test_random();
        obs_t got, exp;
        logic [15:0] seq;
        int          pos;
        for (int it = 0; it < 24; it++) begin
            seq = m_code;
            case ($urandom_range(3, 0))
                0: seq = m_code;
                1: begin
                    pos = int'($urandom_range(3, 0));
                    seq[4*pos +: 4] = seq[4*pos +: 4] ^ 4'($urandom_range(15, 1));
                end
                2: seq = 16'($urandom);
                default: begin
                    repeat ($urandom_range(3, 1)) send_digit(4'($urandom));
                    bus.clear = 1'b1;
                    tick();
                    bus.clear = 1'b0;
                    seq = ($urandom_range(1, 0) == 1) ? m_code : 16'($urandom);
                end
            endcase
            send_seq(seq, 2);
            observe(1'b0, got);
            exp = predict(seq);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random%0d seq=%h got=%p exp=%p", it, seq, got, exp); end
        end
    endtask

`ifdef CODE_PROG_EN
    task automatic test_prog();
        obs_t got, exp;
        send_seq(m_code, 0);
        tick(); tick();
        checks++;
        if (bus.unlocked !== 1'b1) begin errors++; $display("FAIL prog_open got=%b exp=1", bus.unlocked); end
        m_tries = MAX_TRIES;
        bus.prog = 1'b1; tick(); bus.prog = 1'b0;
        checks++;
        if ({bus.unlocked, bus.ready} !== 2'b01) begin
            errors++; $display("FAIL prog_enter got=%b exp=01", {bus.unlocked, bus.ready});
        end
        send_seq(16'h4321, 0);
        m_code = 16'h4321;
        checks++;
        if ({bus.unlocked, bus.ready} !== 2'b01) begin
            errors++; $display("FAIL prog_done got=%b exp=01", {bus.unlocked, bus.ready});
        end
        send_seq(16'h4321, 0);
        observe(1'b0, got);
        exp = predict(16'h4321);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL prog_new_code got=%p exp=%p", got, exp); end
        send_seq(16'hEEEE, 0);
        observe(1'b0, got);
        exp = predict(16'hEEEE);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL prog_old_code got=%p exp=%p", got, exp); end
        // aborted programming keeps the code
        send_seq(16'h4321, 0);
        tick(); tick();
        m_tries = MAX_TRIES;
        bus.prog = 1'b1; tick(); bus.prog = 1'b0;
        send_digit(4'h5);
        send_digit(4'h6);
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        send_seq(16'h4321, 0);
        observe(1'b0, got);
        exp = predict(16'h4321);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL prog_abort got=%p exp=%p", got, exp); end
    endtask
`endif

    initial begin
        bus.digit_valid  = 1'b0; bus.digit  = '0; bus.clear  = 1'b0; bus.prog  = 1'b0;
        bus2.digit_valid = 1'b0; bus2.digit = '0; bus2.clear = 1'b0; bus2.prog = 1'b0;
        test_reset();
        test_unlock();
        test_lockout();
        test_clear();
        test_async_reset();
        test_wide();
        test_random();
`ifdef CODE_PROG_EN
        test_prog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
